signed_sort4: RTL

Sequential sorting stage placed directly downstream of the 4-bit signed less-than comparator. It consumes that comparator's A<B result as its only ordering decision.
- Collects a frame of DEPTH 4-bit two's-complement samples over a valid/ready input.
- Sorts the frame in place with one compare-and-swap per cycle using one comparator instance.
- Streams the frame out in ascending signed order over a valid/ready output.

---
 rtl/signed_sort4.sv | 231 +++++++++++++++++++++++
 1 files changed

// File: rtl/signed_sort4.sv
// signed_sort4 - sequential sorting stage for frames of 4-bit signed samples.
//
// Collects DEPTH two's-complement samples, sorts them in place with one
// compare-and-swap per cycle, then streams them out in ascending signed order.
// Only a single signed less-than comparator is used. It always sees
// A = mem[j+1] and B = mem[j].
//
// Handshake (both sides): a beat transfers on the rising clk edge where
// valid && ready. Valid never depends on ready. Data is captured only on a
// transfer. A stalled output holds out_valid and out_data unchanged.
//
// Optional build macro: SIGNED_SORT_EARLY_EXIT_EN. When it is defined, a pass
// in which no swap occurs ends the sort early. When it is undefined, the sort
// always runs (DEPTH-1)^2 cycles. Output data is the same in both builds.
//
// Ports:
//   clk        rising-edge clock
//   rst_n      asynchronous active-low reset (aborts any frame in flight)
//   in_valid   upstream sample present
//   in_ready   sample accepted this cycle (LOAD only)
//   in_data    4-bit signed sample
//   out_valid  sorted sample present (DRAIN only)
//   out_ready  downstream accepts the sample
//   out_data   4-bit signed sorted sample, driven from registers
//   out_last   final sample of the frame
//   busy       high in SORT or DRAIN
module signed_sort4 #(
  parameter int DEPTH = 4
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       in_valid,
  output logic       in_ready,
  input  logic [3:0] in_data,
  output logic       out_valid,
  input  logic       out_ready,
  output logic [3:0] out_data,
  output logic       out_last,
  output logic       busy
);

  localparam int IW = $clog2(DEPTH);
  localparam logic [IW-1:0] IDX_LAST = IW'(DEPTH - 1);
  localparam logic [IW-1:0] IDX_PEN  = IW'(DEPTH - 2);

  typedef enum logic [1:0] {
    ST_LOAD  = 2'd0,
    ST_SORT  = 2'd1,
    ST_DRAIN = 2'd2
  } state_t;

  state_t        state_q, state_d;
  logic [IW-1:0] wr_idx_q, wr_idx_d;
  logic [IW-1:0] j_q, j_d;
  logic [IW-1:0] pass_q, pass_d;
  logic [IW-1:0] rd_idx_q, rd_idx_d;
  logic [3:0]    mem_q [DEPTH];
  logic [3:0]    mem_d [DEPTH];

  logic [IW-1:0] j_p1;
  logic [3:0]    cmp_a, cmp_b;
  logic          a_lt_b;
  logic          swap;
  logic          pass_end;
  logic          last_pass;
  logic          early_exit;
  logic          sort_done;
  logic          in_xfer, out_xfer;

  // The one comparator: signed A < B. Equal values never swap, which keeps
  // the sort stable and means a frame of ties produces no swap strobes.
  assign j_p1   = j_q + IW'(1);
  assign cmp_a  = mem_q[j_p1];
  assign cmp_b  = mem_q[j_q];
  assign a_lt_b = $signed(cmp_a) < $signed(cmp_b);

  assign swap      = (state_q == ST_SORT) && a_lt_b;
  assign pass_end  = (j_q == IDX_PEN);
  assign last_pass = (pass_q == IDX_PEN);
  assign in_xfer   = in_valid && in_ready;
  assign out_xfer  = out_valid && out_ready;

`ifdef SIGNED_SORT_EARLY_EXIT_EN
  logic swapped_q, swapped_d;

  // The swap on the pass's final compare counts toward that same pass.
  assign early_exit = pass_end && !(swapped_q || swap);

  always_comb begin
    swapped_d = 1'b0;
    if (state_q == ST_SORT && !pass_end) begin
      swapped_d = swapped_q || swap;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      swapped_q <= 1'b0;
    end else begin
      swapped_q <= swapped_d;
    end
  end
`else
  assign early_exit = 1'b0;
`endif

  assign sort_done = (state_q == ST_SORT) && pass_end && (last_pass || early_exit);

  // ---------------------------------------------------------------------
  // FSM: state register
  // ---------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_LOAD;
    end else begin
      state_q <= state_d;
    end
  end

  // ---------------------------------------------------------------------
  // FSM: next-state logic
  // ---------------------------------------------------------------------
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_LOAD: begin
        if (in_xfer && wr_idx_q == IDX_LAST) state_d = ST_SORT;
      end
      ST_SORT: begin
        if (sort_done) state_d = ST_DRAIN;
      end
      ST_DRAIN: begin
        if (out_xfer && rd_idx_q == IDX_LAST) state_d = ST_LOAD;
      end
      default: state_d = ST_LOAD;
    endcase
  end

  // ---------------------------------------------------------------------
  // FSM: outputs (registers only, nothing combinational from inputs)
  // ---------------------------------------------------------------------
  always_comb begin
    in_ready  = 1'b0;
    out_valid = 1'b0;
    out_last  = 1'b0;
    out_data  = 4'd0;
    busy      = 1'b0;
    case (state_q)
      ST_LOAD: begin
        in_ready = 1'b1;
      end
      ST_SORT: begin
        busy = 1'b1;
      end
      ST_DRAIN: begin
        busy      = 1'b1;
        out_valid = 1'b1;
        out_data  = mem_q[rd_idx_q];
        out_last  = (rd_idx_q == IDX_LAST);
      end
      default: begin
        in_ready = 1'b0;
      end
    endcase
  end

  // ---------------------------------------------------------------------
  // Datapath next-state
  // ---------------------------------------------------------------------
  always_comb begin
    wr_idx_d = wr_idx_q;
    j_d      = j_q;
    pass_d   = pass_q;
    rd_idx_d = rd_idx_q;
    mem_d    = mem_q;
    case (state_q)
      ST_LOAD: begin
        if (in_xfer) begin
          mem_d[wr_idx_q] = in_data;
          if (wr_idx_q == IDX_LAST) begin
            wr_idx_d = '0;
            j_d      = '0;
            pass_d   = '0;
          end else begin
            wr_idx_d = wr_idx_q + IW'(1);
          end
        end
      end
      ST_SORT: begin
        if (swap) begin
          mem_d[j_q]  = mem_q[j_p1];
          mem_d[j_p1] = mem_q[j_q];
        end
        if (pass_end) begin
          j_d    = '0;
          // Leave pass at zero once sorting ends so the next frame starts clean.
          pass_d = sort_done ? '0 : pass_q + IW'(1);
        end else begin
          j_d = j_p1;
        end
      end
      ST_DRAIN: begin
        if (out_xfer) begin
          rd_idx_d = (rd_idx_q == IDX_LAST) ? '0 : rd_idx_q + IW'(1);
        end
      end
      default: begin
        rd_idx_d = '0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_idx_q <= '0;
      j_q      <= '0;
      pass_q   <= '0;
      rd_idx_q <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= 4'd0;
      end
    end else begin
      wr_idx_q <= wr_idx_d;
      j_q      <= j_d;
      pass_q   <= pass_d;
      rd_idx_q <= rd_idx_d;
      mem_q    <= mem_d;
    end
  end

endmodule
